// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM load sequencer.
// Imported by the counter and the top-level FSM.
package vram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 16;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/vram_addr_ctr.sv
// Word address and written-word counter for one load pass.
// The address stops at DEPTH-1; the count keeps the total.
module vram_addr_ctr
    import vram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   count,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    assign tc = (addr == LAST);

    // Clear on a new load, advance on each committed write
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr  <= '0;
            count <= '0;
        end else if (clr) begin
            addr  <= '0;
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
            if (!tc) addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/vram_load_ctrl.sv
// Frame buffer loader: copies the image ROM or fills a constant
// colour into VRAM, writing only inside the display write window.
module vram_load_ctrl
    import vram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 1024,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] fill_colour,
    input  logic              abort,
    input  logic              wr_allow,
    output logic [ADDR_W-1:0] rom_ad,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] vram_ad,
    output logic [DATA_W-1:0] vram_data,
    output logic              vram_ce,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

    state_t            state;
    state_t            nxt;
    logic [1:0]        lat_cnt;
    logic              mode_r;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-1:0] addr;
    logic              tc;
    logic              ctr_clr;
    logic              wr_go;
    logic              lat_hit;

    assign lat_hit = (lat_cnt == LAT_LAST);
    assign ctr_clr = (state == ST_IDLE) && start;
    assign wr_go   = (state == ST_WRITE) && wr_allow && !abort;

    // Next-state decode; abort overrides everything outside IDLE
    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (start)
                          nxt = (mode == MODE_FILL) ? ST_WRITE : ST_FETCH;
            ST_FETCH: nxt = ST_WAIT;
            ST_WAIT:  if (lat_hit) nxt = ST_WRITE;
            ST_WRITE: if (wr_allow) begin
                          if (tc)
                              nxt = ST_DONE;
                          else if (mode_r == MODE_FILL)
                              nxt = ST_WRITE;
                          else
                              nxt = ST_FETCH;
                      end
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (abort && state != ST_IDLE) nxt = ST_IDLE;
    end

    // State, latched load settings, ROM latency count, write data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            mode_r  <= MODE_COPY;
            data_r  <= '0;
        end else begin
            state <= nxt;
            if (ctr_clr) begin
                mode_r <= mode;
                data_r <= fill_colour;
            end
            if (state == ST_FETCH)
                lat_cnt <= '0;
            else if (state == ST_WAIT)
                lat_cnt <= lat_cnt + 2'd1;
            if (state == ST_WAIT && lat_hit)
                data_r <= rom_data;
        end
    end

    vram_addr_ctr #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .en    (wr_go),
        .addr  (addr),
        .count (words_written),
        .tc    (tc)
    );

    assign rom_ad    = addr;
    assign rom_ce    = (state == ST_FETCH);
    assign vram_ad   = addr;
    assign vram_data = data_r;
    assign vram_ce   = wr_go;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_vram_load_ctrl.sv
// Directed bench for vram_load_ctrl: fill, copy, stall, abort,
// reset and ROM latency scenarios across three configurations.
module tb_vram_load_ctrl;

    typedef struct {
        logic [9:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] fill_colour = '0;
    logic        abort = 1'b0;
    logic        wr_allow = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic [9:0]  rad_a, rad_b, rad_c, vad_a, vad_b, vad_c;
    logic        rce_a, rce_b, rce_c, vce_a, vce_b, vce_c;
    logic [15:0] rdat_a, rdat_b, rdat_c, vd_a, vd_b, vd_c;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [10:0] ww_a, ww_b, ww_c;
    logic [15:0] rc1, rc2;

    int cyc = 0;
    int errs = 0;
    int checks = 0;
    int dn_a = 0, dn_b = 0, dn_c = 0;
    int dcyc_a = 0, dcyc_b = 0, dcyc_c = 0;
    wr_t qa[$];
    wr_t qb[$];
    wr_t qc[$];
    int  qr_c[$];

    always #5 clk = ~clk;

    vram_load_ctrl #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024), .ROM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode),
        .fill_colour(fill_colour), .abort(abort), .wr_allow(wr_allow),
        .rom_ad(rad_a), .rom_ce(rce_a), .rom_data(rdat_a),
        .vram_ad(vad_a), .vram_data(vd_a), .vram_ce(vce_a),
        .busy(busy_a), .done(done_a), .words_written(ww_a));

    vram_load_ctrl #(.ADDR_W(10), .DATA_W(16), .DEPTH(4), .ROM_LAT(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .fill_colour(fill_colour), .abort(abort), .wr_allow(wr_allow),
        .rom_ad(rad_b), .rom_ce(rce_b), .rom_data(rdat_b),
        .vram_ad(vad_b), .vram_data(vd_b), .vram_ce(vce_b),
        .busy(busy_b), .done(done_b), .words_written(ww_b));

    vram_load_ctrl #(.ADDR_W(10), .DATA_W(16), .DEPTH(2), .ROM_LAT(3)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode),
        .fill_colour(fill_colour), .abort(abort), .wr_allow(wr_allow),
        .rom_ad(rad_c), .rom_ce(rce_c), .rom_data(rdat_c),
        .vram_ad(vad_c), .vram_data(vd_c), .vram_ce(vce_c),
        .busy(busy_c), .done(done_c), .words_written(ww_c));

    // ROM models: word = A000+addr, only valid exactly ROM_LAT after ce
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rdat_a <= rce_a ? 16'hA000 + {6'd0, rad_a} : 16'hDEAD;
        rdat_b <= rce_b ? 16'hA000 + {6'd0, rad_b} : 16'hDEAD;
        rc1    <= rce_c ? 16'hA000 + {6'd0, rad_c} : 16'hDEAD;
        rc2    <= rc1;
        rdat_c <= rc2;
    end

    // Log writes, done pulses and ROM reads mid-cycle
    always @(negedge clk) begin
        if (vce_a) qa.push_back('{a: vad_a, d: vd_a, c: cyc});
        if (vce_b) qb.push_back('{a: vad_b, d: vd_b, c: cyc});
        if (vce_c) qc.push_back('{a: vad_c, d: vd_c, c: cyc});
        if (rce_c) qr_c.push_back(cyc);
        if (done_a) begin dn_a = dn_a + 1; dcyc_a = cyc; end
        if (done_b) begin dn_b = dn_b + 1; dcyc_b = cyc; end
        if (done_c) begin dn_c = dn_c + 1; dcyc_c = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (busy_a !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done_a); end
        checks++; if (vce_a !== 1'b0) begin errs++; $display("FAIL reset_vram_ce: got %b want 0", vce_a); end
        checks++; if (rce_a !== 1'b0) begin errs++; $display("FAIL reset_rom_ce: got %b want 0", rce_a); end
        checks++; if (ww_a !== 11'd0) begin errs++; $display("FAIL reset_words: got %0d want 0", ww_a); end
        checks++; if (vad_a !== 10'd0) begin errs++; $display("FAIL reset_vram_ad: got %0d want 0", vad_a); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill_full();
        int d0, c0, bad;
        qa.delete();
        d0 = dn_a;
        mode = 1'b1; fill_colour = 16'hF800; wr_allow = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 1100 && dn_a == d0; i++) tick();
        checks++; if (dn_a !== d0 + 1) begin errs++; $display("FAIL fill_done_count: got %0d want %0d", dn_a, d0 + 1); end
        checks++; if (qa.size() !== 1024) begin errs++; $display("FAIL fill_writes: got %0d want 1024", qa.size()); end
        bad = 0;
        for (int i = 0; i < qa.size(); i++)
            if (qa[i].a !== 10'(i) || qa[i].d !== 16'hF800 || qa[i].c !== c0 + i) bad++;
        checks++; if (bad !== 0) begin errs++; $display("FAIL fill_seq: got %0d bad want 0", bad); end
        checks++; if (dcyc_a !== c0 + 1024) begin errs++; $display("FAIL fill_done_cyc: got %0d want %0d", dcyc_a - c0, 1024); end
        checks++; if (ww_a !== 11'd1024) begin errs++; $display("FAIL fill_words: got %0d want 1024", ww_a); end
        checks++; if (busy_a !== 1'b0) begin errs++; $display("FAIL fill_busy_end: got %b want 0", busy_a); end
    endtask

    task automatic test_abort();
        int d0;
        qa.delete();
        d0 = dn_a;
        mode = 1'b1; fill_colour = 16'h1234;
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (10) tick();
        abort = 1'b1;
        @(negedge clk);
        checks++; if (vce_a !== 1'b0) begin errs++; $display("FAIL abort_vram_ce: got %b want 0", vce_a); end
        tick();
        abort = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b want 0", busy_a); end
        checks++; if (ww_a !== 11'd10) begin errs++; $display("FAIL abort_words: got %0d want 10", ww_a); end
        repeat (3) tick();
        checks++; if (qa.size() !== 10) begin errs++; $display("FAIL abort_writes: got %0d want 10", qa.size()); end
        checks++; if (dn_a !== d0) begin errs++; $display("FAIL abort_no_done: got %0d want %0d", dn_a, d0); end
        qa.delete();
        fill_colour = 16'h001F;
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (3) tick();
        checks++; if (qa.size() !== 3) begin errs++; $display("FAIL restart_writes: got %0d want 3", qa.size()); end
        checks++; if (qa.size() > 0 && (qa[0].a !== 10'd0 || qa[0].d !== 16'h001F)) begin
            errs++; $display("FAIL restart_first: got %0d/%h want 0/001f", qa[0].a, qa[0].d);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_start_ignored();
        int bad;
        qa.delete();
        mode = 1'b1; fill_colour = 16'hF800;
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        start_a = 1'b1; mode = 1'b0; fill_colour = 16'h07E0;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        checks++; if (qa.size() !== 5) begin errs++; $display("FAIL busy_start_writes: got %0d want 5", qa.size()); end
        bad = 0;
        for (int i = 0; i < qa.size(); i++)
            if (qa[i].a !== 10'(i) || qa[i].d !== 16'hF800) bad++;
        checks++; if (bad !== 0) begin errs++; $display("FAIL busy_start_latch: got %0d bad want 0", bad); end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_start_abort_same();
        qa.delete();
        mode = 1'b1; fill_colour = 16'hFFFF;
        start_a = 1'b1; abort = 1'b1;
        tick();
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errs++; $display("FAIL sa_busy_on: got %b want 1", busy_a); end
        tick();
        abort = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errs++; $display("FAIL sa_busy_off: got %b want 0", busy_a); end
        checks++; if (ww_a !== 11'd0 || qa.size() !== 0) begin
            errs++; $display("FAIL sa_no_write: got %0d/%0d want 0/0", ww_a, qa.size());
        end
    endtask

    task automatic test_reset_mid_copy();
        mode = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        checks++; if (rce_a !== 1'b1 || rad_a !== 10'd0) begin
            errs++; $display("FAIL copy_fetch0: got %b/%0d want 1/0", rce_a, rad_a);
        end
        repeat (7) tick();
        checks++; if (ww_a !== 11'd2 || vad_a !== 10'd2 || vd_a !== 16'hA001) begin
            errs++; $display("FAIL pre_rst_state: got %0d/%0d/%h want 2/2/a001", ww_a, vad_a, vd_a);
        end
        rst = 1'b0;
        tick();
        checks++; if ({rce_a, vce_a, busy_a, done_a} !== 4'b0 || rad_a !== 10'd0 || vad_a !== 10'd0
                      || vd_a !== 16'd0 || ww_a !== 11'd0) begin
            errs++; $display("FAIL rst_mid_copy: got %b%b%b%b %0d %0d %h %0d want all 0",
                             rce_a, vce_a, busy_a, done_a, rad_a, vad_a, vd_a, ww_a);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_copy();
        int d0, c0, bad;
        qb.delete();
        d0 = dn_b; mode = 1'b0; wr_allow = 1'b1;
        start_b = 1'b1; tick(); start_b = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 40 && dn_b == d0; i++) tick();
        checks++; if (qb.size() !== 4) begin errs++; $display("FAIL copy_writes: got %0d want 4", qb.size()); end
        bad = 0;
        for (int i = 0; i < qb.size(); i++)
            if (qb[i].a !== 10'(i) || qb[i].d !== 16'hA000 + 16'(i) || qb[i].c !== c0 + 2 + 3 * i) bad++;
        checks++; if (bad !== 0) begin errs++; $display("FAIL copy_seq: got %0d bad want 0", bad); end
        checks++; if (dn_b !== d0 + 1 || dcyc_b !== c0 + 12) begin
            errs++; $display("FAIL copy_done: got %0d@%0d want %0d@12", dn_b, dcyc_b - c0, d0 + 1);
        end
        checks++; if (ww_b !== 11'd4) begin errs++; $display("FAIL copy_words: got %0d want 4", ww_b); end
    endtask

    task automatic test_stall();
        int d0, c0;
        qb.delete();
        d0 = dn_b; mode = 1'b0; wr_allow = 1'b1;
        start_b = 1'b1; tick(); start_b = 1'b0;
        c0 = cyc;
        repeat (8) tick();
        wr_allow = 1'b0;
        repeat (5) tick();
        wr_allow = 1'b1;
        for (int i = 0; i < 40 && dn_b == d0; i++) tick();
        checks++; if (qb.size() !== 4) begin errs++; $display("FAIL stall_writes: got %0d want 4", qb.size()); end
        checks++; if (qb.size() > 2 && (qb[2].a !== 10'd2 || qb[2].d !== 16'hA002 || qb[2].c !== c0 + 13)) begin
            errs++; $display("FAIL stall_word2: got %0d/%h@%0d want 2/a002@13", qb[2].a, qb[2].d, qb[2].c - c0);
        end
        checks++; if (dcyc_b !== c0 + 17) begin errs++; $display("FAIL stall_done_cyc: got %0d want 17", dcyc_b - c0); end
    endtask

    task automatic test_lat3();
        int d0, c0;
        qc.delete(); qr_c.delete();
        d0 = dn_c; mode = 1'b0; wr_allow = 1'b1;
        start_c = 1'b1; tick(); start_c = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 40 && dn_c == d0; i++) tick();
        checks++; if (qr_c.size() !== 2) begin errs++; $display("FAIL lat3_rom_ce_count: got %0d want 2", qr_c.size()); end
        checks++; if (qr_c.size() == 2 && (qr_c[0] !== c0 || qr_c[1] !== c0 + 5)) begin
            errs++; $display("FAIL lat3_rom_ce_cyc: got %0d,%0d want 0,5", qr_c[0] - c0, qr_c[1] - c0);
        end
        checks++; if (qc.size() !== 2) begin errs++; $display("FAIL lat3_writes: got %0d want 2", qc.size()); end
        checks++; if (qc.size() == 2 && (qc[0].d !== 16'hA000 || qc[0].c !== c0 + 4
                      || qc[1].a !== 10'd1 || qc[1].d !== 16'hA001 || qc[1].c !== c0 + 9)) begin
            errs++; $display("FAIL lat3_data: got %h@%0d %0d/%h@%0d want a000@4 1/a001@9",
                             qc[0].d, qc[0].c - c0, qc[1].a, qc[1].d, qc[1].c - c0);
        end
        checks++; if (dn_c !== d0 + 1 || dcyc_c !== c0 + 10) begin
            errs++; $display("FAIL lat3_done: got %0d@%0d want %0d@10", dn_c, dcyc_c - c0, d0 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_abort();
        test_start_ignored();
        test_start_abort_same();
        test_reset_mid_copy();
        test_copy();
        test_stall();
        test_lat3();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
